// File: rtl/rot_patch_coord_gen.sv
// Rotated patch coordinate generator.
// Accepts a cos/sin pair per patch and streams the rounded, saturated
// rotated (rx, ry) offset of every cell of a PATCH_W x PATCH_W patch,
// row-major, under valid/ready flow control.
module rot_patch_coord_gen #(
    parameter int ADDR_W      = 4,
    parameter int TRIG_W      = 12,
    parameter int FRAC        = 10,
    parameter int SCALE_SHIFT = 0,
    parameter int OUT_W       = 5,
    parameter int RANGE       = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [TRIG_W-1:0] cos_in,
    input  logic signed [TRIG_W-1:0] sin_in,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*ADDR_W-1:0]      out_addr,
    output logic signed [OUT_W-1:0]  out_rx,
    output logic signed [OUT_W-1:0]  out_ry,
    output logic                     out_in_range,
    output logic                     out_last,
    output logic                     done
);

    localparam int PATCH_W = 2 ** ADDR_W;
    // Width of the centred odd coordinate 2*idx-(PATCH_W-1)
    localparam int CW      = ADDR_W + 2;
    localparam int SH      = FRAC + 1 + SCALE_SHIFT;
    // Product/sum width: covers u*cos - v*sin with headroom, and the rounding bias
    localparam int PW_BASE = TRIG_W + ADDR_W + 3;
    localparam int PW      = (PW_BASE > SH + 1) ? PW_BASE : SH + 2;

    localparam logic [ADDR_W-1:0]    LAST_IDX   = ADDR_W'(PATCH_W - 1);
    localparam logic signed [CW-1:0] CENTRE     = CW'(PATCH_W - 1);
    localparam logic signed [PW-1:0] ROUND_BIAS = PW'(1) <<< (SH - 1);
    localparam logic signed [PW-1:0] OUT_MAX    = PW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PW-1:0] OUT_MIN    = PW'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;

    logic signed [TRIG_W-1:0]  cos_r;
    logic signed [TRIG_W-1:0]  sin_r;
    logic [ADDR_W-1:0]         row_r;
    logic [ADDR_W-1:0]         col_r;

    logic                      accept_s;
    logic                      load_s;
    logic                      beat_load_s;
    logic                      adv_s;
    logic                      fin_s;

    logic [ADDR_W-1:0]         nxt_row_s;
    logic [ADDR_W-1:0]         nxt_col_s;
    logic [ADDR_W-1:0]         beat_row_s;
    logic [ADDR_W-1:0]         beat_col_s;
    logic signed [PW-1:0]      u_s;
    logic signed [PW-1:0]      v_s;
    logic signed [PW-1:0]      cos_w_s;
    logic signed [PW-1:0]      sin_w_s;
    logic signed [PW-1:0]      px_s;
    logic signed [PW-1:0]      py_s;
    logic signed [OUT_W-1:0]   rx_s;
    logic signed [OUT_W-1:0]   ry_s;
    logic                      inr_s;
    logic                      last_s;

    // Map a cell index to its centred odd coordinate, sign-extended to PW bits
    function automatic logic signed [PW-1:0] centre_coord(input logic [ADDR_W-1:0] idx);
        logic signed [CW-1:0] c;
        c = $signed({1'b0, idx, 1'b0}) - CENTRE;
        centre_coord = PW'(c);
    endfunction

    // Round half toward +inf, arithmetic shift down, then clip to OUT_W signed
    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = (p + ROUND_BIAS) >>> SH;
        if (r > OUT_MAX) begin
            round_sat = OUT_MAX[OUT_W-1:0];
        end else if (r < OUT_MIN) begin
            round_sat = OUT_MIN[OUT_W-1:0];
        end else begin
            round_sat = r[OUT_W-1:0];
        end
    endfunction

    // True when |a| <= RANGE
    function automatic logic range_ok(input logic signed [OUT_W-1:0] a);
        int a_i;
        a_i = int'(a);
        range_ok = (a_i <= RANGE) && (a_i >= -RANGE);
    endfunction

    assign out_addr = {row_r, col_r};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        beat_load_s = 1'b0;
        adv_s       = 1'b0;
        fin_s       = 1'b0;
        accept_s    = out_valid && out_ready;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_STREAM;
                beat_load_s = 1'b1;
            end
            ST_STREAM: begin
                if (accept_s) begin
                    if (out_last) begin
                        state_nxt_s = ST_FIN;
                        fin_s       = 1'b1;
                    end else begin
                        state_nxt_s = ST_STREAM;
                        adv_s       = 1'b1;
                        beat_load_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Beat datapath: pick the cell being registered next and rotate it
    always_comb begin
        nxt_col_s = col_r + ADDR_W'(1);
        if (col_r == LAST_IDX) begin
            nxt_row_s = row_r + ADDR_W'(1);
        end else begin
            nxt_row_s = row_r;
        end
        if (state_r == ST_LOAD) begin
            beat_row_s = row_r;
            beat_col_s = col_r;
        end else begin
            beat_row_s = nxt_row_s;
            beat_col_s = nxt_col_s;
        end
        u_s     = centre_coord(beat_col_s);
        v_s     = centre_coord(beat_row_s);
        cos_w_s = PW'(cos_r);
        sin_w_s = PW'(sin_r);
        px_s    = (u_s * cos_w_s) - (v_s * sin_w_s);
        py_s    = (u_s * sin_w_s) + (v_s * cos_w_s);
        rx_s    = round_sat(px_s);
        ry_s    = round_sat(py_s);
        inr_s   = range_ok(rx_s) && range_ok(ry_s);
        last_s  = (beat_row_s == LAST_IDX) && (beat_col_s == LAST_IDX);
    end

    // Latched angle, cell counters and registered output beat
    always_ff @(posedge clk) begin
        if (rst) begin
            cos_r        <= '0;
            sin_r        <= '0;
            row_r        <= '0;
            col_r        <= '0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_rx       <= '0;
            out_ry       <= '0;
            out_in_range <= 1'b0;
            out_last     <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= fin_s;
            if (load_s) begin
                cos_r <= cos_in;
                sin_r <= sin_in;
                row_r <= '0;
                col_r <= '0;
                busy  <= 1'b1;
            end
            if (adv_s) begin
                row_r <= nxt_row_s;
                col_r <= nxt_col_s;
            end
            if (beat_load_s) begin
                out_valid    <= 1'b1;
                out_rx       <= rx_s;
                out_ry       <= ry_s;
                out_in_range <= inr_s;
                out_last     <= last_s;
            end
            if (fin_s) begin
                busy         <= 1'b0;
                out_valid    <= 1'b0;
                row_r        <= '0;
                col_r        <= '0;
                out_rx       <= '0;
                out_ry       <= '0;
                out_in_range <= 1'b0;
                out_last     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rot_patch_coord_gen.md
Name: rot_patch_coord_gen

Overview:
- Sequential, parametrised successor to the per-angle distributed coordinate ROMs used in SIFT descriptor generation.
- A single instance replaces one ROM per orientation bin. Per patch it takes a cos/sin pair from the orientation stage and streams the rotated, rounded, saturated (rx, ry) offset for every cell of a PATCH_W x PATCH_W patch.
- It sits between orientation assignment and the descriptor histogram accumulator.
- Relative to the fixed tables it adds: runtime angle, both axes, programmable scale, saturation, an in-range flag, and valid/ready flow control.

Parameters:
- ADDR_W, 4, bits per patch axis; PATCH_W = 2**ADDR_W.
- TRIG_W, 12, signed width of cos_in/sin_in.
- FRAC, 10, fractional bits of cos_in/sin_in (1.0 = 2**FRAC).
- SCALE_SHIFT, 0, extra right shift applied to the rotated product (>=0).
- OUT_W, 5, signed width of out_rx/out_ry.
- RANGE, 7, |rx| and |ry| limit used for out_in_range.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a patch; accepted only when busy=0.
- cos_in  in  TRIG_W  signed cos(theta)*2**FRAC; sampled with an accepted start.
- sin_in  in  TRIG_W  signed sin(theta)*2**FRAC; sampled with an accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_addr  out  2*ADDR_W  {row, col} of the current cell.
- out_rx  out  OUT_W  signed rotated x offset.
- out_ry  out  OUT_W  signed rotated y offset.
- out_in_range  out  1  |out_rx|<=RANGE and |out_ry|<=RANGE.
- out_last  out  1  marks the final cell (row=col=PATCH_W-1).
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; internal cos/sin/row/col registers cleared. Reset takes effect mid-patch too: the stream is abandoned and no done pulse is issued.
- FSM states: IDLE, LOAD, STREAM, FIN.
  - IDLE --start--> LOAD: latch cos_in and sin_in; row=col=0.
  - LOAD -> STREAM: register the first beat; out_valid=1 two cycles after the start cycle.
  - STREAM: a beat is accepted when out_valid && out_ready. On acceptance, advance col; when col wraps from PATCH_W-1 to 0, increment row. The next beat is registered in the same edge, so with out_ready held high there is 1 beat/cycle and no bubbles.
  - STREAM -> FIN when the out_last beat is accepted: out_valid=0, done=1 for that one cycle, busy=0.
  - FIN -> IDLE next cycle.
- start is ignored in any state other than IDLE, including the FIN cycle. cos/sin changes during a patch are ignored.
- Backpressure: while out_valid=1 and out_ready=0, out_addr, out_rx, out_ry, out_in_range and out_last are held bit-stable.
- Arithmetic per cell, with cos/sin as the latched values:
  - Centred odd coordinates: u = 2*col-(PATCH_W-1), v = 2*row-(PATCH_W-1).
  - px = u*cos - v*sin; py = u*sin + v*cos; full precision, no intermediate overflow.
  - SH = FRAC+1+SCALE_SHIFT.
  - rx = (px + 2**(SH-1)) >>> SH, i.e. round half toward +inf, arithmetic shift. ry is computed the same way from py.
  - Saturate rx and ry to [-2**(OUT_W-1), 2**(OUT_W-1)-1].
  - out_in_range is computed on the saturated values.
- out_last=1 only on cell {PATCH_W-1, PATCH_W-1}.
- A back-to-back patch requires a new start. Minimum gap: done cycle, FIN, IDLE.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0, no out_valid.
- cos=1024, sin=0, out_ready=1, defaults -> first beat 2 cycles after start. Beat 0: addr 0x00, rx=-7, ry=-7. Beat 15: addr 0x0F, rx=8, ry=-7. Beat 255: rx=8, ry=8, out_last=1. 256 consecutive beats, then done pulse, busy=0.
- cos=0, sin=1024 (90 deg) -> addr 0x00: rx=8, ry=-7. addr 0xF0: rx=-7, ry=-7. addr 0x0F: rx=8, ry=8.
- OUT_W=4, cos=2047, sin=0 -> addr 0x0F: rx=7 (saturated from 15). addr 0x00: rx=-8 (saturated from -15), out_in_range=0 on both beats.
- cos=1024, sin=0, out_ready toggled randomly and held low for 3 cycles at addr 0x37 -> outputs stable throughout, sequence gap-free and in order, exactly 256 acceptances.
- rst asserted at beat 100; start pulses issued while busy -> next cycle: outputs 0, FSM in IDLE, no done pulse. Starts issued while busy have no effect. A fresh start afterwards produces a full 256-beat patch.
